// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and the write-entry record for the register-file write arbiter.
package reg_write_arbiter_pkg;

  localparam int unsigned AW         = 3;
  localparam int unsigned DW_DEFAULT = 8;

  // One pending register-file write; data width follows the default data width.
  typedef struct packed {
    logic                  valid;
    logic [AW-1:0]         addr;
    logic [DW_DEFAULT-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write buffer: shift-style FIFO (entry 0 is the head) with a two-entry
// push port, single pop, occupancy count and per-entry address compare.
module wb_fifo
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wr_entry_t,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push0,
  input  entry_t        push0_entry,
  input  logic          push1,
  input  entry_t        push1_entry,
  input  logic          pop,
  input  logic [AW-1:0] cmp_addr1,
  input  logic [AW-1:0] cmp_addr2,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          match1,
  output logic          match2
);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [CW-1:0]   base;

  // Next contents: shift out the head on pop, then append push0 and push1 in order.
  always_comb begin
    mem_d = mem_q;
    base  = count_q;
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
      mem_d[DEPTH-1] = '0;
      base = count_q - CW'(1);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push0 && (CW'(i) == base)) begin
        mem_d[i]       = push0_entry;
        mem_d[i].valid = 1'b1;
      end
      if (push1 && (CW'(i) == (base + CW'(push0)))) begin
        mem_d[i]       = push1_entry;
        mem_d[i].valid = 1'b1;
      end
    end
    count_d = base + CW'(push0) + CW'(push1);
  end

  // Storage and occupancy registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Address compare of both read ports against every valid entry.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem_q[i].valid && (mem_q[i].addr == cmp_addr1)) match1 = 1'b1;
      if (mem_q[i].valid && (mem_q[i].addr == cmp_addr2)) match2 = 1'b1;
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates ALU and load write-backs onto the single register-file write port,
// buffering the loser, tracking read hazards and counting issued writes.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ALU_REQ,
  input  logic [AW-1:0] ALU_ADDR,
  input  logic [DW-1:0] ALU_DATA,
  input  logic          MEM_REQ,
  input  logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_DATA,
  input  logic          HOLD,
  input  logic [AW-1:0] RD_ADDR1,
  input  logic [AW-1:0] RD_ADDR2,
  output logic          RF_WRITE,
  output logic [AW-1:0] RF_INADDR,
  output logic [DW-1:0] RF_IN,
  output logic          ALU_ACK,
  output logic          MEM_ACK,
  output logic          STALL,
  output logic          HAZ1,
  output logic          HAZ2,
  output logic [7:0]    WR_COUNT
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem_e;
  entry_t        alu_e;
  entry_t        cand;
  entry_t        push0_e;
  entry_t        push1_e;
  entry_t        buf_head;
  logic          push0_en;
  logic          push1_en;
  logic          buf_pop;
  logic [CW-1:0] buf_count;
  logic          buf_match1;
  logic          buf_match2;

  // Accept only while the buffer can absorb a same-cycle pair and nothing stalls.
  assign STALL   = RESET | HOLD | (buf_count >= CW'(DEPTH - 1));
  assign ALU_ACK = ALU_REQ & ~STALL;
  assign MEM_ACK = MEM_REQ & ~STALL;

  assign mem_e = entry_t'{valid: 1'b1, addr: MEM_ADDR, data: MEM_DATA};
  assign alu_e = entry_t'{valid: 1'b1, addr: ALU_ADDR, data: ALU_DATA};

  // Issue pick: oldest buffered write first, then MEM, then ALU; the rest queue up.
  always_comb begin
    cand     = '0;
    push0_e  = mem_e;
    push1_e  = alu_e;
    push0_en = 1'b0;
    push1_en = 1'b0;
    buf_pop  = 1'b0;
    if (buf_count != '0) begin
      cand     = buf_head;
      buf_pop  = ~HOLD & ~RESET;
      push0_en = MEM_ACK;
      push1_en = ALU_ACK;
    end else if (MEM_ACK) begin
      cand     = mem_e;
      push0_e  = alu_e;
      push0_en = ALU_ACK;
    end else if (ALU_ACK) begin
      cand     = alu_e;
    end
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .push0       (push0_en),
    .push0_entry (push0_e),
    .push1       (push1_en),
    .push1_entry (push1_e),
    .pop         (buf_pop),
    .cmp_addr1   (RD_ADDR1),
    .cmp_addr2   (RD_ADDR2),
    .head        (buf_head),
    .count       (buf_count),
    .match1      (buf_match1),
    .match2      (buf_match2)
  );

  // Register-file write port and issue counter; HOLD freezes all but RF_WRITE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RF_WRITE  <= 1'b0;
      RF_INADDR <= '0;
      RF_IN     <= '0;
      WR_COUNT  <= '0;
    end else if (HOLD) begin
      RF_WRITE  <= 1'b0;
    end else begin
      RF_WRITE <= cand.valid;
      if (cand.valid) begin
        RF_INADDR <= cand.addr;
        RF_IN     <= cand.data;
        WR_COUNT  <= WR_COUNT + 8'd1;
      end
    end
  end

  // A read hazards on the in-flight write or on anything still buffered.
  assign HAZ1 = (RF_WRITE && (RD_ADDR1 == RF_INADDR)) || buf_match1;
  assign HAZ2 = (RF_WRITE && (RD_ADDR2 == RF_INADDR)) || buf_match2;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios then random traffic,
// compared against a queue-based model of pending writes and a model register file.
module tb_reg_write_arbiter;

  localparam int DEPTH = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ALU_REQ = 1'b0;
  logic [2:0] ALU_ADDR = '0;
  logic [7:0] ALU_DATA = '0;
  logic       MEM_REQ = 1'b0;
  logic [2:0] MEM_ADDR = '0;
  logic [7:0] MEM_DATA = '0;
  logic       HOLD = 1'b0;
  logic [2:0] RD_ADDR1 = '0;
  logic [2:0] RD_ADDR2 = '0;
  logic       RF_WRITE;
  logic [2:0] RF_INADDR;
  logic [7:0] RF_IN;
  logic       ALU_ACK;
  logic       MEM_ACK;
  logic       STALL;
  logic       HAZ1;
  logic       HAZ2;
  logic [7:0] WR_COUNT;

  reg_write_arbiter #(.DEPTH(DEPTH), .DW(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_REQ(ALU_REQ), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .HOLD(HOLD), .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
    .RF_WRITE(RF_WRITE), .RF_INADDR(RF_INADDR), .RF_IN(RF_IN),
    .ALU_ACK(ALU_ACK), .MEM_ACK(MEM_ACK), .STALL(STALL),
    .HAZ1(HAZ1), .HAZ2(HAZ2), .WR_COUNT(WR_COUNT)
  );

  always #5 CLK = ~CLK;

  // Register file as written by the DUT's write port.
  logic [7:0] a_rf [8];
  initial for (int i = 0; i < 8; i++) a_rf[i] = 8'h00;
  always @(posedge CLK) if (RF_WRITE) a_rf[RF_INADDR] <= RF_IN;

  // Reference model: accepted-but-not-issued writes, the issued write and the expected file.
  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t        pend[$];
  logic       exp_wr = 1'b0;
  logic [2:0] exp_addr = '0;
  logic [7:0] exp_data = '0;
  logic [7:0] exp_cnt = '0;
  logic [7:0] m_rf [8];
  initial for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance the model across the edge,
  // then check registered outputs; requests that were accepted are withdrawn.
  task automatic cycle();
    logic e_stall, e_aack, e_mack, e_h1, e_h2;
    wr_t  w;
    #1;
    e_stall = RESET | HOLD | (pend.size() >= DEPTH - 1);
    e_aack  = ALU_REQ & ~e_stall;
    e_mack  = MEM_REQ & ~e_stall;
    e_h1    = exp_wr && (RD_ADDR1 == exp_addr);
    e_h2    = exp_wr && (RD_ADDR2 == exp_addr);
    foreach (pend[i]) begin
      if (pend[i].a == RD_ADDR1) e_h1 = 1'b1;
      if (pend[i].a == RD_ADDR2) e_h2 = 1'b1;
    end
    chk("stall",   32'(STALL),   32'(e_stall));
    chk("alu_ack", 32'(ALU_ACK), 32'(e_aack));
    chk("mem_ack", 32'(MEM_ACK), 32'(e_mack));
    chk("haz1",    32'(HAZ1),    32'(e_h1));
    chk("haz2",    32'(HAZ2),    32'(e_h2));
    @(posedge CLK);
    if (exp_wr) m_rf[exp_addr] = exp_data;
    if (RESET) begin
      pend.delete();
      exp_wr   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_cnt  = '0;
    end else if (HOLD) begin
      exp_wr = 1'b0;
    end else begin
      if (e_mack) pend.push_back('{MEM_ADDR, MEM_DATA});
      if (e_aack) pend.push_back('{ALU_ADDR, ALU_DATA});
      if (pend.size() > 0) begin
        w        = pend.pop_front();
        exp_wr   = 1'b1;
        exp_addr = w.a;
        exp_data = w.d;
        exp_cnt  = exp_cnt + 8'd1;
      end else begin
        exp_wr = 1'b0;
      end
    end
    #1;
    chk("no_overflow", 32'(int'(dut.buf_count) <= DEPTH), 32'd1);
    chk("buf_count",   32'(dut.buf_count), 32'(pend.size()));
    chk("rf_write",    32'(RF_WRITE),  32'(exp_wr));
    chk("rf_inaddr",   32'(RF_INADDR), 32'(exp_addr));
    chk("rf_in",       32'(RF_IN),     32'(exp_data));
    chk("wr_count",    32'(WR_COUNT),  32'(exp_cnt));
    if (e_mack) MEM_REQ = 1'b0;
    if (e_aack) ALU_REQ = 1'b0;
  endtask

  task automatic set_alu(input logic [2:0] a, input logic [7:0] d);
    ALU_REQ = 1'b1; ALU_ADDR = a; ALU_DATA = d;
  endtask

  task automatic set_mem(input logic [2:0] a, input logic [7:0] d);
    MEM_REQ = 1'b1; MEM_ADDR = a; MEM_DATA = d;
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge CLK);
    #1;
    // Reset with requests pending: no acks, STALL high.
    set_alu(3'd2, 8'h99);
    set_mem(3'd3, 8'h98);
    cycle();
    ALU_REQ = 1'b0; MEM_REQ = 1'b0;
    RESET = 1'b0;
    cycle();

    // Scenario 1: single ALU write when idle.
    set_alu(3'd3, 8'h2A);
    cycle();
    chk("s1_count", 32'(WR_COUNT), 32'd1);
    cycle();
    chk("s1_rf3", 32'(a_rf[3]), 32'h2A);

    // Scenario 2: MEM and ALU in the same cycle to different registers.
    set_mem(3'd1, 8'h10);
    set_alu(3'd2, 8'h20);
    repeat (3) cycle();
    chk("s2_rf1", 32'(a_rf[1]), 32'h10);
    chk("s2_rf2", 32'(a_rf[2]), 32'h20);

    // Scenario 3: same-address pair; ALU value must win.
    set_mem(3'd5, 8'h11);
    set_alu(3'd5, 8'h22);
    repeat (3) cycle();
    chk("s3_rf5", 32'(a_rf[5]), 32'h22);
    chk("s3_count", 32'(WR_COUNT), 32'd5);

    // Scenario 4: HOLD for three cycles with one entry buffered.
    set_mem(3'd6, 8'h33);
    set_alu(3'd7, 8'h44);
    cycle();
    HOLD = 1'b1;
    set_alu(3'd1, 8'h45);
    repeat (3) cycle();
    HOLD = 1'b0;
    ALU_REQ = 1'b0;
    cycle();
    chk("s4_issue_addr", 32'(RF_INADDR), 32'd7);
    cycle();
    chk("s4_rf7", 32'(a_rf[7]), 32'h44);

    // Scenario 5: read-after-write hazard on a buffered R4.
    RD_ADDR1 = 3'd4;
    RD_ADDR2 = 3'd1;
    set_mem(3'd1, 8'h55);
    set_alu(3'd4, 8'h66);
    repeat (3) cycle();
    chk("s5_haz1_clear", 32'(HAZ1), 32'd0);
    RD_ADDR1 = 3'd0;
    RD_ADDR2 = 3'd0;

    // Scenario 6: bring WR_COUNT to 255 with one entry buffered, then reset.
    guard = 0;
    while (exp_cnt != 8'd254 && guard < 600) begin
      set_alu(3'd1, 8'(guard));
      cycle();
      guard++;
    end
    chk("s6_reach254", 32'(WR_COUNT), 32'd254);
    set_mem(3'd2, 8'h77);
    set_alu(3'd0, 8'hEE);
    cycle();
    chk("s6_count255", 32'(WR_COUNT), 32'd255);
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    repeat (3) cycle();
    chk("s6_r0_dropped", 32'(a_rf[0]), 32'(m_rf[0]));

    // Wrap: 256 writes return WR_COUNT to 0.
    for (int i = 0; i < 256; i++) begin
      set_alu(3'(i), 8'(i * 3));
      cycle();
    end
    cycle();
    chk("wrap_zero", 32'(WR_COUNT), 32'd0);

    // Random traffic with occasional HOLD and RESET.
    for (int n = 0; n < 800; n++) begin
      if (!ALU_REQ && ($urandom_range(0, 1) == 1)) set_alu(3'($urandom), 8'($urandom));
      if (!MEM_REQ && ($urandom_range(0, 1) == 1)) set_mem(3'($urandom), 8'($urandom));
      HOLD     = ($urandom_range(0, 7) == 0);
      RESET    = ($urandom_range(0, 99) == 0);
      RD_ADDR1 = 3'($urandom);
      RD_ADDR2 = 3'($urandom);
      cycle();
    end
    HOLD = 1'b0; RESET = 1'b0; ALU_REQ = 1'b0; MEM_REQ = 1'b0;
    repeat (4) cycle();
    for (int i = 0; i < 8; i++) chk($sformatf("rf_final_r%0d", i), 32'(a_rf[i]), 32'(m_rf[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, 2, number of pending-write buffer entries (legal range 2-4).
REQ-002 The block SHALL have parameter DW, 8, data width; address width SHALL be fixed at 3.
REQ-003 The block SHALL have port CLK  in  1  clock; all state updates on posedge.
REQ-004 The block SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports ALU_REQ  in  1, ALU_ADDR  in  3, ALU_DATA  in  DW: ALU write-back request.
REQ-006 The block SHALL have ports MEM_REQ  in  1, MEM_ADDR  in  3, MEM_DATA  in  DW: load write-back request.
REQ-007 The block SHALL have port HOLD  in  1  global stall from the memory subsystem.
REQ-008 The block SHALL have ports RD_ADDR1, RD_ADDR2  in  3 each: register-file read addresses for hazard check.
REQ-009 The block SHALL have ports RF_WRITE  out  1, RF_INADDR  out  3, RF_IN  out  DW: registered drive of the register-file write port.
REQ-010 The block SHALL have ports ALU_ACK, MEM_ACK  out  1 each: request accepted this cycle (combinational).
REQ-011 The block SHALL have port STALL  out  1: new requests are not accepted this cycle.
REQ-012 The block SHALL have ports HAZ1, HAZ2  out  1 each: RD_ADDRn targets a pending, not-yet-committed write.
REQ-013 The block SHALL have port WR_COUNT  out  8: number of writes issued, wrapping modulo 256.

Function
REQ-014 STALL SHALL equal HOLD OR (count >= DEPTH-1), where count is the number of valid buffer entries.
REQ-015 ALU_ACK SHALL equal ALU_REQ AND NOT STALL; MEM_ACK SHALL equal MEM_REQ AND NOT STALL.
REQ-016 Unacknowledged requests SHALL be ignored; requesters hold REQ, ADDR and DATA until ACK.
REQ-017 MEM SHALL be treated as program-older than ALU; same-cycle writes SHALL commit MEM first, then ALU.
REQ-018 On each posedge with HOLD low, the issue candidate SHALL be: the buffer head if count>0, else an accepted MEM request, else an accepted ALU request.
REQ-019 If a candidate exists, the block SHALL load it into RF_WRITE=1/RF_INADDR/RF_IN, else set RF_WRITE=0.
REQ-020 Accepted requests not issued SHALL be enqueued at the tail in MEM-then-ALU order.
REQ-021 Each output write SHALL be held for exactly one cycle; the register file commits it at the following posedge.
REQ-022 When idle, the latency from acceptance edge to register commit SHALL be 1 cycle.
REQ-023 With HOLD high, the buffer, the output registers and WR_COUNT SHALL be frozen, and RF_WRITE SHALL be forced to 0 at that posedge.
REQ-024 WR_COUNT SHALL increment by 1 on each posedge that loads RF_WRITE=1, and SHALL wrap from 255 to 0.
REQ-025 HAZn SHALL be high when RD_ADDRn matches RF_INADDR while RF_WRITE=1, or matches any valid buffer entry.
REQ-026 Same-address MEM and ALU requests SHALL both be written, leaving the ALU value in the register.
REQ-027 Count SHALL never exceed DEPTH; an overflow is a design error and the bench SHALL flag it.

Reset
REQ-028 A posedge with RESET high SHALL clear count, buffer valid bits, RF_WRITE, RF_INADDR, RF_IN and WR_COUNT to 0.
REQ-029 RESET SHALL take priority over HOLD and requests, and pending writes SHALL be discarded without commit.
REQ-030 During RESET, ACKs SHALL be 0 and STALL SHALL be 1.

Structure
REQ-031 A shared package SHALL hold: the address width constant (3), the default data width (8), and the write-entry record type (valid, addr, data).
REQ-032 The buffer SHALL be one sub-module, wb_fifo: a DEPTH-entry FIFO with a push-two port, pop, count and per-entry address compare.
REQ-033 Arbitration, issue, hazard logic and WR_COUNT SHALL reside in the top module.

Verification
REQ-034 Scenario 1: idle, ALU_REQ R3=0x2A -> ALU_ACK=1, RF_WRITE=1 with addr 3 and data 0x2A in the next cycle, WR_COUNT=1.
REQ-035 Scenario 2: MEM R1=0x10 and ALU R2=0x20 in the same cycle -> R1 is issued in cycle+1 and R2 in cycle+2, count peaks at 1, STALL=1 for one cycle.
REQ-036 Scenario 3: MEM R5=0x11 and ALU R5=0x22 in the same cycle -> R5 ends at 0x22, WR_COUNT advances by 2.
REQ-037 Scenario 4: HOLD high for 3 cycles with 1 entry pending -> RF_WRITE=0, no ACKs and frozen state; the entry issues on the first edge after HOLD falls.
REQ-038 Scenario 5: RD_ADDR1=4 while an R4 write is buffered -> HAZ1=1 until the cycle after R4 commits, then HAZ1=0.
REQ-039 Scenario 6: RESET asserted with 1 entry buffered and WR_COUNT=255 -> all outputs 0 and the entry is never written; separately, 256 writes wrap WR_COUNT to 0.
